// File: rtl/servo_drv_multi.sv
// Multi-channel servo PWM driver: one shared frame counter, per-channel position to pulse-width
// mapping with optional per-frame slew limiting; targets and enables take effect at frame boundaries.
module servo_drv_multi #(
    parameter int NUM_CH    = 4,
    parameter int POS_W     = 8,
    parameter int CNT_W     = 20,
    parameter int FRAME_CNT = 240000,
    parameter int MIN_T     = 12000,
    parameter int STEP      = 47,
    parameter int SLEW      = 0,
    parameter int RST_POS   = 128,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [POS_W-1:0]  wr_pos,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] srv_o,
    output logic              frm_o,
    output logic [NUM_CH-1:0] settled_o
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CNT - 1);
    localparam logic [POS_W-1:0] SLEW_P   = POS_W'(SLEW);
    localparam logic [POS_W-1:0] RST_P    = POS_W'(RST_POS);

    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cntNext;
    logic              w_boundary;
    logic [NUM_CH-1:0] r_enQ;
    logic [POS_W-1:0]  r_tgt     [NUM_CH];
    logic [POS_W-1:0]  r_cur     [NUM_CH];
    logic [POS_W-1:0]  w_curNext [NUM_CH];
    logic [CNT_W-1:0]  w_onT     [NUM_CH];

    always_comb begin
        w_boundary = (r_cnt == LAST_CNT);
        w_cntNext  = w_boundary ? '0 : r_cnt + 1'b1;
    end

    // Next frame's position: jump to target, or move at most SLEW codes toward it.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_curNext[i] = r_tgt[i];
            if (SLEW != 0) begin
                if ((r_tgt[i] > r_cur[i]) && ((r_tgt[i] - r_cur[i]) > SLEW_P)) begin
                    w_curNext[i] = r_cur[i] + SLEW_P;
                end else if ((r_cur[i] > r_tgt[i]) && ((r_cur[i] - r_tgt[i]) > SLEW_P)) begin
                    w_curNext[i] = r_cur[i] - SLEW_P;
                end
            end
            w_onT[i] = CNT_W'(MIN_T) + CNT_W'(r_cur[i]) * CNT_W'(STEP);
        end
    end

    // frm_o is registered from cnt==0 so it lines up with the first high cycle of every pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_enQ     <= '0;
            srv_o     <= '0;
            frm_o     <= 1'b0;
            settled_o <= '1;
            for (int i = 0; i < NUM_CH; i++) begin
                r_tgt[i] <= RST_P;
                r_cur[i] <= RST_P;
            end
        end else begin
            r_cnt <= w_cntNext;
            frm_o <= (r_cnt == '0);
            for (int i = 0; i < NUM_CH; i++) begin
                srv_o[i]     <= r_enQ[i] && (r_cnt < w_onT[i]);
                settled_o[i] <= (r_cur[i] == r_tgt[i]);
                if (w_boundary) begin
                    r_enQ[i] <= ch_en[i];
                    r_cur[i] <= w_curNext[i];
                end
                if (wr_en && (int'(wr_ch) == i)) begin
                    r_tgt[i] <= wr_pos;
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_drv_multi.sv
// Randomized and directed bench for servo_drv_multi: two instances (unlimited and slew-limited)
// share stimulus; a frame-level reference model feeds a scoreboard checked by a separate monitor.
module tb_servo_drv_multi;

    localparam int NCH     = 3;
    localparam int POS_W   = 8;
    localparam int CNT_W   = 20;
    localparam int FRAME   = 300;
    localparam int MIN_T   = 10;
    localparam int STEP    = 1;
    localparam int RST_POS = 40;
    localparam int SLEW_B  = 8;

    if (MIN_T + (2**POS_W - 1) * STEP >= FRAME) begin : gBadParams
        initial begin
            $display("[TB] FAIL paramCheck: max pulse %0d, frame %0d", MIN_T + (2**POS_W - 1) * STEP, FRAME);
            $fatal(1, "[TB] invalid parameter set");
        end
    end

    typedef struct packed {
        logic [1:0][NCH-1:0][15:0] width;
        logic [1:0][NCH-1:0]       settled;
    } frame_t;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [1:0]     wr_ch = '0;
    logic [POS_W-1:0] wr_pos = '0;
    logic [NCH-1:0] ch_en = '0;
    logic [NCH-1:0] srvA, srvB, setA, setB;
    logic           frmA, frmB;

    int nChecks = 0;
    int nPass = 0;
    int framesChecked = 0;

    always #5 clk = ~clk;

    servo_drv_multi #(
        .NUM_CH(NCH), .POS_W(POS_W), .CNT_W(CNT_W), .FRAME_CNT(FRAME),
        .MIN_T(MIN_T), .STEP(STEP), .SLEW(0), .RST_POS(RST_POS)
    ) dutA (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .srv_o(srvA), .frm_o(frmA), .settled_o(setA)
    );

    servo_drv_multi #(
        .NUM_CH(NCH), .POS_W(POS_W), .CNT_W(CNT_W), .FRAME_CNT(FRAME),
        .MIN_T(MIN_T), .STEP(STEP), .SLEW(SLEW_B), .RST_POS(RST_POS)
    ) dutB (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_pos(wr_pos),
        .ch_en(ch_en), .srv_o(srvB), .frm_o(frmB), .settled_o(setB)
    );

    task automatic checkOutput(input string name, input int act, input int exp);
        nChecks++;
        if (act == exp) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: frame position in the counter plus per-channel target/current/enable.
    int     mcnt = 0;
    int     tgtM [2][NCH];
    int     curM [2][NCH];
    bit     enM  [2][NCH];
    frame_t expQ [$];

    function automatic frame_t snapshot();
        frame_t f;
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NCH; i++) begin
                f.width[k][i]   = enM[k][i] ? 16'(MIN_T + curM[k][i] * STEP) : 16'd0;
                f.settled[k][i] = (curM[k][i] == tgtM[k][i]);
            end
        end
        return f;
    endfunction

    task automatic modelWrite();
        if (wr_en && int'(wr_ch) < NCH) begin
            for (int k = 0; k < 2; k++) tgtM[k][int'(wr_ch)] = int'(wr_pos);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            mcnt = 0;
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NCH; i++) begin
                    tgtM[k][i] = RST_POS;
                    curM[k][i] = RST_POS;
                    enM[k][i]  = 1'b0;
                end
            end
            expQ.delete();
            expQ.push_back(snapshot());
        end else if (mcnt == FRAME - 1) begin
            for (int k = 0; k < 2; k++) begin
                for (int i = 0; i < NCH; i++) begin
                    int d;
                    int s;
                    d = tgtM[k][i] - curM[k][i];
                    s = (k == 0) ? 0 : SLEW_B;
                    enM[k][i] = ch_en[i];
                    if (s == 0 || (d <= s && d >= -s)) curM[k][i] = tgtM[k][i];
                    else curM[k][i] = curM[k][i] + ((d > 0) ? s : -s);
                end
            end
            modelWrite();
            expQ.push_back(snapshot());
            mcnt = 0;
        end else begin
            modelWrite();
            mcnt++;
        end
    end

    // Monitor: measures each output frame and compares it against the queued expectation.
    int             hi [2][NCH];
    bit             active = 1'b0;
    logic [1:0][NCH-1:0] startSrv, startSet;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            active = 1'b0;
        end else begin
            if (mcnt == 1 || frmA || frmB) begin
                checkOutput("frmA", int'(frmA), int'(mcnt == 1));
                checkOutput("frmB", int'(frmB), int'(mcnt == 1));
            end
            if (mcnt == 1) begin
                if (active) begin
                    if (expQ.size() == 0) begin
                        checkOutput("scoreboardEmpty", 0, 1);
                    end else begin
                        frame_t e;
                        e = expQ.pop_front();
                        framesChecked++;
                        for (int k = 0; k < 2; k++) begin
                            for (int i = 0; i < NCH; i++) begin
                                checkOutput($sformatf("width[%0d][%0d]", k, i), hi[k][i], int'(e.width[k][i]));
                                checkOutput($sformatf("pulseStart[%0d][%0d]", k, i),
                                            int'(startSrv[k][i]), int'(e.width[k][i] != 0));
                                checkOutput($sformatf("settled[%0d][%0d]", k, i),
                                            int'(startSet[k][i]), int'(e.settled[k][i]));
                            end
                        end
                    end
                end
                active = 1'b1;
                startSrv[0] = srvA;
                startSrv[1] = srvB;
                startSet[0] = setA;
                startSet[1] = setB;
                for (int k = 0; k < 2; k++) for (int i = 0; i < NCH; i++) hi[k][i] = 0;
            end
            if (active) begin
                for (int i = 0; i < NCH; i++) begin
                    hi[0][i] += int'(srvA[i]);
                    hi[1][i] += int'(srvB[i]);
                end
            end
        end
    end

    task automatic applyReset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rstSrvA", int'(srvA), 0);
        checkOutput("rstSrvB", int'(srvB), 0);
        checkOutput("rstFrm", int'(frmA | frmB), 0);
        checkOutput("rstSettledA", int'(setA), (1 << NCH) - 1);
        checkOutput("rstSettledB", int'(setB), (1 << NCH) - 1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic waitCnt(input int v);
        int n;
        n = 0;
        @(negedge clk);
        while (mcnt != v && n < 2 * FRAME) begin
            @(negedge clk);
            n++;
        end
        if (mcnt != v) checkOutput("waitCntTimeout", mcnt, v);
    endtask

    task automatic writePos(input int ch, input int pos);
        wr_en  = 1'b1;
        wr_ch  = 2'(ch);
        wr_pos = POS_W'(pos);
        @(negedge clk);
        wr_en  = 1'b0;
    endtask

    task automatic runFrames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic applyStimulus();
        applyReset();
        ch_en = 3'b111;
        runFrames(3);
        waitCnt(150);
        writePos(0, 0);
        writePos(1, 80);
        runFrames(2);
        writePos(0, 70);
        writePos(2, 255);
        runFrames(6);
        waitCnt(FRAME - 2);
        writePos(0, 100);
        waitCnt(FRAME - 1);
        writePos(1, 200);
        runFrames(3);
        waitCnt(30);
        ch_en = 3'b101;
        runFrames(2);
        writePos(3, 7);
        runFrames(1);
        ch_en = 3'b111;
        runFrames(1);
        waitCnt(20);
        applyReset();
        runFrames(3);
        for (int c = 0; c < 12 * FRAME; c++) begin
            wr_en = ($urandom_range(0, 29) == 0);
            if (wr_en) begin
                wr_ch = 2'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       wr_pos = '0;
                    1:       wr_pos = '1;
                    default: wr_pos = POS_W'($urandom);
                endcase
            end
            if ($urandom_range(0, 399) == 0) ch_en = NCH'($urandom);
            @(negedge clk);
        end
        wr_en = 1'b0;
        runFrames(2);
    endtask

    initial begin
        applyStimulus();
        checkOutput("framesChecked>=25", int'(framesChecked >= 25), 1);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
